ext_arbiter: RTL and testbench

EXT_ARBITER -- requirements
Module: ext_arbiter

---
 rtl/ext_arb_pkg.sv | 15 +
 rtl/ext_arb_grant.sv | 31 +++
 rtl/ext_arbiter.sv | 127 ++++++++++++
 tb/tb_ext_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_arb_pkg.sv
// Shared definitions for the sign-extender arbiter: FSM encoding, requester IDs, counter width.
package ext_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/ext_arb_grant.sv
// One-hot grant selection between two requesters.
// EXT_ARB_RR_EN: round-robin on contention (i_ptr names the favoured requester); otherwise requester 0 wins.
module ext_arb_grant
  import ext_arb_pkg::*;
(
  input  logic       i_valid0,
  input  logic       i_valid1,
`ifdef EXT_ARB_RR_EN
  input  logic       i_ptr,
`endif
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
`ifdef EXT_ARB_RR_EN
    if (i_valid0 && i_valid1) begin
      o_grant = (i_ptr == REQ_ID_1) ? 2'b10 : 2'b01;
    end else begin
      o_grant = {i_valid1, i_valid0};
    end
`else
    if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/ext_arbiter.sv
// Two-requester front end for an external shared sign extender of DELAY register stages.
// EXT_ARB_RR_EN selects round-robin arbitration; default build is fixed priority (requester 0).
//
// state | meaning
// IDLE  | free; accepts one request when enabled
// WAIT  | operand held on ext_dataIn, counting down the extender latency
// RESP  | result on resp_data, owner's resp_valid high until consumed
module ext_arbiter
  import ext_arb_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int DELAY     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_n,
  input  logic                 req0_valid,
  input  logic [IN_WIDTH-1:0]  req0_data,
  input  logic                 req0_signed,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [IN_WIDTH-1:0]  req1_data,
  input  logic                 req1_signed,
  output logic                 req1_ready,
  output logic [IN_WIDTH-1:0]  ext_dataIn,
  output logic                 ext_isSigned,
  input  logic [OUT_WIDTH-1:0] ext_dataOut,
  output logic                 resp0_valid,
  output logic                 resp1_valid,
  output logic [OUT_WIDTH-1:0] resp_data,
  output logic                 busy
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_owner;
  logic [IN_WIDTH-1:0]  r_data;
  logic                 r_signed;
  logic [OUT_WIDTH-1:0] r_resp;
  logic [1:0]           w_grant;
  logic                 w_grant_id;
  logic                 w_accept;
  logic                 w_capture;
`ifdef EXT_ARB_RR_EN
  logic                 r_ptr;
`endif

  ext_arb_grant u_grant (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
`ifdef EXT_ARB_RR_EN
    .i_ptr    (r_ptr),
`endif
    .o_grant  (w_grant)
  );

  assign w_grant_id = w_grant[1] ? REQ_ID_1 : REQ_ID_0;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Gated by rst so a requester never sees a strobe for a cycle that reset discards.
        if (!en_n && !rst && (w_grant != 2'b00)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!en_n && (r_cnt == '0)) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!en_n) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_owner  <= REQ_ID_0;
      r_data   <= '0;
      r_signed <= 1'b0;
      r_resp   <= '0;
`ifdef EXT_ARB_RR_EN
      r_ptr    <= REQ_ID_0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data   <= w_grant[1] ? req1_data   : req0_data;
        r_signed <= w_grant[1] ? req1_signed : req0_signed;
        r_owner  <= w_grant_id;
        r_cnt    <= CNT_W'(DELAY);
`ifdef EXT_ARB_RR_EN
        r_ptr    <= ~w_grant_id;
`endif
      end else if ((r_state == ST_WAIT) && !en_n && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_resp <= ext_dataOut;
      end
    end
  end

  assign req0_ready   = w_accept & w_grant[0];
  assign req1_ready   = w_accept & w_grant[1];
  assign ext_dataIn   = r_data;
  assign ext_isSigned = r_signed;
  assign resp_data    = r_resp;
  assign resp0_valid  = (r_state == ST_RESP) && (r_owner == REQ_ID_0);
  assign resp1_valid  = (r_state == ST_RESP) && (r_owner == REQ_ID_1);
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ext_arbiter.sv
// Self-checking bench for ext_arbiter: transaction-level model compared every cycle, plus directed literal checks.
module tb_ext_arbiter;

  localparam int IW  = 16;
  localparam int OW  = 32;
  localparam int DLY = 2;

  typedef struct packed {
    logic [IW-1:0] d;
    logic          s;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en_n;
  logic          v0, v1, s0, s1;
  logic [IW-1:0] d0, d1;
  logic          rdy0, rdy1, ext_sg, rv0, rv1, busy;
  logic [IW-1:0] ext_din;
  logic [OW-1:0] ext_dout, rdata;

  logic          b_v0, b_s0, b_v1, b_s1, b_en_n;
  logic [IW-1:0] b_d0, b_d1;
  logic          b_rdy0, b_rdy1, b_ext_sg, b_rv0, b_rv1, b_busy;
  logic [IW-1:0] b_ext_din;
  logic [OW-1:0] b_ext_dout, b_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic logic [OW-1:0] extend(input logic [IW-1:0] d, input logic s);
    return s ? {{(OW-IW){d[IW-1]}}, d} : {{(OW-IW){1'b0}}, d};
  endfunction

  ext_arbiter #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DELAY(DLY)) u_dut (
    .clk(clk), .rst(rst), .en_n(en_n),
    .req0_valid(v0), .req0_data(d0), .req0_signed(s0), .req0_ready(rdy0),
    .req1_valid(v1), .req1_data(d1), .req1_signed(s1), .req1_ready(rdy1),
    .ext_dataIn(ext_din), .ext_isSigned(ext_sg), .ext_dataOut(ext_dout),
    .resp0_valid(rv0), .resp1_valid(rv1), .resp_data(rdata), .busy(busy)
  );

  ext_arbiter #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DELAY(0)) u_dut_d0 (
    .clk(clk), .rst(rst), .en_n(b_en_n),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_signed(b_s0), .req0_ready(b_rdy0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_signed(b_s1), .req1_ready(b_rdy1),
    .ext_dataIn(b_ext_din), .ext_isSigned(b_ext_sg), .ext_dataOut(b_ext_dout),
    .resp0_valid(b_rv0), .resp1_valid(b_rv1), .resp_data(b_rdata), .busy(b_busy)
  );

  // External extenders: two register stages for the main DUT, combinational for the DELAY=0 one.
  logic [OW-1:0] pipe0, pipe1;
  always @(posedge clk) begin
    pipe0 <= extend(ext_din, ext_sg);
    pipe1 <= pipe0;
  end
  assign ext_dout   = pipe1;
  assign b_ext_dout = extend(b_ext_din, b_ext_sg);

  task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Requester agents: hold the head of each queue on the bus until its ready is seen.
  op_t q0[$], q1[$];
  logic seen0 = 1'b0, seen1 = 1'b0;
  int   glog[$];

  task automatic push(input int id, input logic [IW-1:0] d, input logic s);
    op_t o;
    o.d = d;
    o.s = s;
    if (id == 0) q0.push_back(o); else q1.push_back(o);
  endtask

  always @(posedge clk) begin
    cyc++;
    #3;
    if (seen0 && q0.size() > 0) q0.delete(0);
    if (seen1 && q1.size() > 0) q1.delete(0);
    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    d0 = v0 ? q0[0].d : '0;
    s0 = v0 ? q0[0].s : 1'b0;
    d1 = v1 ? q1[0].d : '0;
    s1 = v1 ? q1[0].s : 1'b0;
  end

  // Model: one operation in flight, aged in enabled cycles; result visible at age DLY+2.
  logic          chk_en = 1'b0;
  logic          m_active, m_sg;
  int            m_age, m_owner, m_ptr;
  logic [IW-1:0] m_data;
  logic [OW-1:0] m_resp;

  function automatic int pick(input logic a, input logic b, input int ptr);
    if (a && b) begin
`ifdef EXT_ARB_RR_EN
      return ptr;
`else
      return 0;
`endif
    end
    return a ? 0 : 1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      chk_en   = 1'b1;
      m_active = 1'b0;
      m_age    = 0;
      m_owner  = 0;
      m_ptr    = 0;
      m_data   = '0;
      m_sg     = 1'b0;
      m_resp   = '0;
    end else if (chk_en && !en_n) begin
      if (!m_active) begin
        if (v0 || v1) begin
          g        = pick(v0, v1, m_ptr);
          m_active = 1'b1;
          m_age    = 1;
          m_owner  = g;
          m_data   = (g == 0) ? d0 : d1;
          m_sg     = (g == 0) ? s0 : s1;
          m_ptr    = 1 - g;
        end
      end else if (m_age == DLY + 2) begin
        m_active = 1'b0;
      end else begin
        if (m_age == DLY + 1) m_resp = extend(m_data, m_sg);
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    logic er;
    int   g;
    seen0 = rdy0;
    seen1 = rdy1;
    if (rdy0) glog.push_back(0);
    if (rdy1) glog.push_back(1);
    if (chk_en) begin
      er = !m_active && !en_n && !rst && (v0 || v1);
      g  = pick(v0, v1, m_ptr);
      check("ready0", rdy0, er && (g == 0));
      check("ready1", rdy1, er && (g == 1));
      check("busy", busy, m_active);
      check("resp0_valid", rv0, m_active && (m_age == DLY + 2) && (m_owner == 0));
      check("resp1_valid", rv1, m_active && (m_age == DLY + 2) && (m_owner == 1));
      check("resp_data", rdata, m_resp);
      check("ext_dataIn", ext_din, m_data);
      check("ext_isSigned", ext_sg, m_sg);
    end
  end

  function automatic logic sig(input int id);
    case (id)
      0: return rdy0;
      1: return rdy1;
      2: return rv0;
      3: return rv1;
      4: return b_rdy0;
      default: return b_rv0;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int id, input int lim, output int t);
    int i;
    i = 0;
    @(negedge clk);
    while (!sig(id) && i < lim) begin
      @(negedge clk);
      i++;
    end
    check(nm, sig(id), 1'b1);
    t = cyc;
  endtask

  task automatic drain(input string nm, input int lim);
    int i;
    i = 0;
    @(negedge clk);
    while ((q0.size() > 0 || q1.size() > 0 || busy || v0 || v1) && i < lim) begin
      @(negedge clk);
      i++;
    end
    check(nm, (i < lim), 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int t0, t1, n0, n1;
    int exp_order[4];
    rst = 1'b1; en_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; s0 = 1'b0; s1 = 1'b0;
    b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = '0; b_d1 = '0; b_s0 = 1'b0; b_s1 = 1'b0; b_en_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_data", rdata, 32'h0);
    check("rst_ext_dataIn", ext_din, 16'h0);
    check("rst_resp_valid", {rv0, rv1}, 2'b00);
    check("rst_d0_resp_data", b_rdata, 32'h0);

    // DELAY=0 instance: signed 8001 -> FFFF8001 two cycles after ready.
    @(posedge clk); #1 b_v0 = 1'b1; b_d0 = 16'h8001; b_s0 = 1'b1;
    wait_for("d0_ready0_seen", 4, 10, t0);
    @(posedge clk); #1 b_v0 = 1'b0;
    @(negedge clk);
    check("d0_ready_single_pulse", b_rdy0, 1'b0);
    wait_for("d0_resp0_seen", 5, 10, t1);
    check("d0_latency", t1 - t0, 2);
    check("d0_resp_data", b_rdata, 32'hFFFF8001);

    // DELAY=2: zero-extend on requester 1, latency 4, busy over T+1..T+4.
    @(posedge clk); #1 push(1, 16'h8001, 1'b0);
    wait_for("s035_ready1_seen", 1, 10, t0);
    check("s035_busy_at_ready", busy, 1'b0);
    wait_for("s035_resp1_seen", 3, 20, t1);
    check("s035_latency", t1 - t0, 4);
    check("s035_resp_data", rdata, 32'h00008001);
    check("s035_busy_at_resp", busy, 1'b1);
    @(negedge clk);
    check("s035_busy_after", busy, 1'b0);

    // Contention: both requesters hold valid for several operations.
    do_reset();
    glog.delete();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      push(0, 16'h8000 | 16'(k), k[0]);
      push(1, 16'h0F00 + 16'(k), 1'b1);
    end
`ifdef EXT_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    drain("s036_drain", 200);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s036_grant%0d", k), (glog.size() > k) ? glog[k] : 9, exp_order[k]);
    end
    check("s036_total_grants", glog.size(), 8);

    // Three-cycle stall while waiting pushes the response out by exactly three cycles.
    @(posedge clk); #1 push(0, 16'h1234, 1'b1);
    wait_for("s037_ready0_seen", 0, 10, t0);
    @(posedge clk); #1 en_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 en_n = 1'b0;
    wait_for("s037_resp0_seen", 2, 20, t1);
    check("s037_latency", t1 - t0, DLY + 2 + 3);
    check("s037_resp_data", rdata, 32'h00001234);

    // Stall during RESP holds resp_valid and data.
    @(posedge clk); #1 push(1, 16'hF0F0, 1'b1);
    wait_for("s037b_resp1_seen", 3, 20, t1);
    #1 en_n = 1'b1;
    @(negedge clk);
    check("s037b_hold1", rv1, 1'b1);
    @(negedge clk);
    check("s037b_hold2", rv1, 1'b1);
    check("s037b_data", rdata, 32'hFFFFF0F0);
    #1 en_n = 1'b0;
    @(negedge clk);
    check("s037b_released", rv1, 1'b0);

    // Reset in WAIT aborts silently; requester 0 wins the next contention.
    glog.delete();
    @(posedge clk); #1 push(1, 16'h8001, 1'b1);
    wait_for("s038_ready1_seen", 1, 10, t0);
    @(posedge clk); #1;
    push(0, 16'h0005, 1'b0);
    push(1, 16'h7FFF, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("s038_busy", busy, 1'b0);
    check("s038_resp_data", rdata, 32'h0);
    check("s038_no_resp", {rv0, rv1}, 2'b00);
    check("s038_req0_wins", {rdy1, rdy0}, 2'b01);
    wait_for("s038_resp0_seen", 2, 20, t1);
    check("s038_resp0_data", rdata, 32'h00000005);
    drain("s038_drain", 100);

    // Request arriving while busy waits for IDLE and is served exactly once.
    glog.delete();
    @(posedge clk); #1 push(1, 16'h4321, 1'b0);
    wait_for("s039_ready1_seen", 1, 10, t0);
    @(posedge clk); #1 push(0, 16'hABCD, 1'b1);
    wait_for("s039_ready0_seen", 0, 20, t1);
    check("s039_gap", t1 - t0, DLY + 3);
    wait_for("s039_resp0_seen", 2, 20, t1);
    check("s039_resp0_data", rdata, 32'hFFFFABCD);
    drain("s039_drain", 100);
    n0 = 0;
    n1 = 0;
    foreach (glog[k]) begin
      if (glog[k] == 0) n0++; else n1++;
    end
    check("s039_grants_req0", n0, 1);
    check("s039_grants_req1", n1, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
